mem_stage_access_ctrl: RTL and testbench

- Memory-stage access controller. Sits directly downstream of the EX/MEM pipeline register and upstream of the MEM/WB register.
- Turns the pipelined MEM control bundle into a handshaked request to a multi-cycle data memory, and stalls the front of the pipeline until the access completes.
- Applies MEM-to-MEM forwarding of store data from the instruction in WB.
- Returns registered load data to the MEM/WB register.

---
 rtl/mem_stage_access_ctrl.sv | 175 +++++++++++++++++
 tb/tb_mem_stage_access_ctrl.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_access_ctrl.sv
// Memory-stage access controller.
// Converts the EX/MEM memory control bundle into a single handshaked request
// to a multi-cycle data memory. While the access is outstanding it holds the
// front of the pipeline, and it returns registered load data to MEM/WB.
// Store data can be forwarded from the instruction that is currently in WB.
module mem_stage_access_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] EX_MEM_ALU_out,
    input  logic [17:0] EX_MEM_MEM_signals,
    input  logic [3:0]  EX_MEM_SrcReg2,
    input  logic        MEM_WB_RegWrite,
    input  logic [3:0]  MEM_WB_reg_rd,
    input  logic [15:0] MEM_WB_write_data,
    output logic        dmem_req,
    output logic        dmem_wr,
    output logic [15:0] dmem_addr,
    output logic [15:0] dmem_wdata,
    input  logic [15:0] dmem_rdata,
    input  logic        dmem_ready,
    output logic        MEM_stall,
    output logic [15:0] MEM_rdata,
    output logic        mem_err
);

    // The wait counter runs from 0 up to TIMEOUT_CYCLES-1. The counter is
    // sized for the largest allowed timeout.
    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 32'd1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // This bundle is captured once per access and then held constant.
    typedef struct packed {
        logic        wr;
        logic [15:0] addr;
        logic [15:0] wdata;
    } mem_req_t;

    state_t      state_q, state_d;
    mem_req_t    req_fields_q;
    logic        req_q;
    logic [15:0] wait_cnt_q;
    logic [15:0] rdata_q;
    logic        err_q;

    // These are fields of the EX/MEM control bundle.
    logic [15:0] mem_write_data;
    logic        mem_enable;
    logic        mem_write;

    assign mem_write_data = EX_MEM_MEM_signals[17:2];
    assign mem_enable     = EX_MEM_MEM_signals[1];
    assign mem_write      = EX_MEM_MEM_signals[0];

    // MEM-to-MEM forwarding: when the WB instruction writes the store-data
    // source register, its value is used. Register 0 is never a forwarding
    // source.
    logic        fwd;
    logic [15:0] store_data;

    assign fwd        = mem_write & MEM_WB_RegWrite
                      & (MEM_WB_reg_rd == EX_MEM_SrcReg2)
                      & (MEM_WB_reg_rd != 4'd0);
    assign store_data = fwd ? MEM_WB_write_data : mem_write_data;

    // Access start and completion events. A ready response takes priority
    // over a timeout that falls in the same cycle. Ready is only meaningful
    // while in BUSY.
    logic start_acc;
    logic ready_hit;
    logic timeout_hit;

    assign start_acc   = (state_q == IDLE) & mem_enable;
    assign ready_hit   = (state_q == BUSY) & dmem_ready;
    assign timeout_hit = (state_q == BUSY) & ~dmem_ready & (wait_cnt_q == CNT_LAST);

    // Next-state logic and stall generation. DONE releases the stall for one
    // cycle so that EX/MEM can advance without the same access issuing twice.
    always_comb begin
        state_d   = state_q;
        MEM_stall = 1'b0;
        case (state_q)
            IDLE: begin
                if (mem_enable) begin
                    MEM_stall = 1'b1;
                    state_d   = BUSY;
                end
            end
            BUSY: begin
                MEM_stall = 1'b1;
                if (ready_hit || timeout_hit) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Request register. The fields are captured at issue, and req drops when
    // the access completes or is aborted.
    always_ff @(posedge clk) begin
        if (rst) begin
            req_q        <= 1'b0;
            req_fields_q <= '0;
        end else if (start_acc) begin
            req_q              <= 1'b1;
            req_fields_q.wr    <= mem_write;
            req_fields_q.addr  <= EX_MEM_ALU_out;
            req_fields_q.wdata <= store_data;
        end else if (ready_hit || timeout_hit) begin
            req_q <= 1'b0;
        end
    end

    // Wait counter. It is cleared at issue and advances on each BUSY cycle
    // that has no ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt_q <= '0;
        end else if (start_acc) begin
            wait_cnt_q <= '0;
        end else if ((state_q == BUSY) && !ready_hit && !timeout_hit) begin
            wait_cnt_q <= wait_cnt_q + 16'd1;
        end
    end

    // Load data return. A read that times out returns zero. A store leaves
    // the last load value in place.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (ready_hit && !req_fields_q.wr) begin
            rdata_q <= dmem_rdata;
        end else if (timeout_hit && !req_fields_q.wr) begin
            rdata_q <= '0;
        end
    end

    // Sticky error flag. Only reset clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (timeout_hit) begin
            err_q <= 1'b1;
        end
    end

    assign dmem_req   = req_q;
    assign dmem_wr    = req_fields_q.wr;
    assign dmem_addr  = req_fields_q.addr;
    assign dmem_wdata = req_fields_q.wdata;
    assign MEM_rdata  = rdata_q;
    assign mem_err    = err_q;

endmodule

// File: tb/tb_mem_stage_access_ctrl.sv
// Scoreboard bench for mem_stage_access_ctrl. A memory responder answers
// requests after a programmable delay. Expected requests and load results are
// queued at issue and popped when the DUT raises or drops dmem_req.
module tb_mem_stage_access_ctrl;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] ex_alu = '0;
    logic [17:0] ex_sig = '0;
    logic [3:0]  ex_src2 = '0;
    logic        wb_rw = 1'b0;
    logic [3:0]  wb_rd = '0;
    logic [15:0] wb_data = '0;
    logic        dmem_req, dmem_wr, MEM_stall, mem_err;
    logic [15:0] dmem_addr, dmem_wdata, MEM_rdata;
    logic [15:0] dmem_rdata;
    logic        dmem_ready;

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [15:0] wdata;
    } req_t;

    req_t        req_q[$];
    logic [15:0] rd_q[$];
    int          n_checks = 0;
    int          n_pass = 0;
    logic [15:0] exp_rdata = '0;
    int          rsp_delay = 0;
    logic        rsp_en = 1'b1;
    logic        manual_ready = 1'b0;
    logic [15:0] manual_rdata = '0;

    mem_stage_access_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .EX_MEM_ALU_out(ex_alu), .EX_MEM_MEM_signals(ex_sig), .EX_MEM_SrcReg2(ex_src2),
        .MEM_WB_RegWrite(wb_rw), .MEM_WB_reg_rd(wb_rd), .MEM_WB_write_data(wb_data),
        .dmem_req(dmem_req), .dmem_wr(dmem_wr), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
        .MEM_stall(MEM_stall), .MEM_rdata(MEM_rdata), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] rd_val(input logic [15:0] a);
        return (a == 16'h0040) ? 16'hBEEF : (a ^ 16'hA5A5);
    endfunction

    // Memory responder. It asserts ready after rsp_delay request cycles, or
    // replays manual values while disabled.
    initial begin
        int wc;
        wc = 0;
        dmem_ready = 1'b0;
        dmem_rdata = '0;
        forever begin
            @(negedge clk);
            if (!rsp_en) begin
                dmem_ready = manual_ready;
                dmem_rdata = manual_rdata;
                wc = 0;
            end else if (dmem_req === 1'b1) begin
                if (wc == rsp_delay) begin
                    dmem_ready = 1'b1;
                    dmem_rdata = rd_val(dmem_addr);
                    wc = 0;
                end else begin
                    dmem_ready = 1'b0;
                    wc++;
                end
            end else begin
                dmem_ready = 1'b0;
                wc = 0;
            end
        end
    end

    // Scoreboard monitor. A rising req pops the expected request, and a
    // falling req pops the expected MEM_rdata.
    initial begin
        logic req_prev, rst_edge;
        req_t e;
        logic [15:0] er;
        req_prev = 1'b0;
        forever begin
            @(posedge clk);
            rst_edge = rst;
            @(negedge clk);
            if (rst_edge) begin
                req_prev = 1'b0;
            end else begin
                if (dmem_req === 1'b1 && !req_prev) begin
                    n_checks++;
                    if (req_q.size() == 0) begin
                        $display("FAIL req_issue: unexpected request addr %h", dmem_addr);
                    end else begin
                        e = req_q.pop_front();
                        if (dmem_wr !== e.wr || dmem_addr !== e.addr || dmem_wdata !== e.wdata)
                            $display("FAIL req_issue: got wr=%b addr=%h wdata=%h, expected wr=%b addr=%h wdata=%h",
                                     dmem_wr, dmem_addr, dmem_wdata, e.wr, e.addr, e.wdata);
                        else n_pass++;
                    end
                end
                if (dmem_req !== 1'b1 && req_prev) begin
                    n_checks++;
                    if (rd_q.size() == 0) begin
                        $display("FAIL rdata_done: unexpected completion, rdata %h", MEM_rdata);
                    end else begin
                        er = rd_q.pop_front();
                        if (MEM_rdata !== er)
                            $display("FAIL rdata_done: got %h, expected %h", MEM_rdata, er);
                        else n_pass++;
                    end
                end
                req_prev = (dmem_req === 1'b1);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // This task is entered just after a posedge and presents one instruction
    // in EX/MEM until the stall releases. It returns just after the edge that
    // advances EX/MEM.
    task automatic run_instr(input logic en, input logic wr, input logic [15:0] addr,
                             input logic [15:0] wd, input logic [3:0] src2, input int delay,
                             input logic [15:0] exp_wd, output int stall_n, output int req_n);
        logic done;
        ex_alu = addr;
        ex_sig = {wd, en, wr};
        ex_src2 = src2;
        rsp_delay = delay;
        if (en) begin
            req_q.push_back('{wr, addr, exp_wd});
            if (!wr) exp_rdata = (delay >= TO) ? 16'h0000 : rd_val(addr);
            rd_q.push_back(exp_rdata);
        end
        stall_n = 0;
        req_n = 0;
        done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (i == 0 && en) begin
                n_checks++;
                if (MEM_stall !== 1'b1 || dmem_req !== 1'b0)
                    $display("FAIL idle_detect: got stall=%b req=%b, expected stall=1 req=0", MEM_stall, dmem_req);
                else n_pass++;
            end
            if (dmem_req === 1'b1) begin
                req_n++;
                n_checks++;
                if (dmem_addr !== addr || dmem_wdata !== exp_wd || dmem_wr !== wr)
                    $display("FAIL req_stable: got addr=%h wdata=%h wr=%b, expected addr=%h wdata=%h wr=%b",
                             dmem_addr, dmem_wdata, dmem_wr, addr, exp_wd, wr);
                else n_pass++;
            end
            if (MEM_stall === 1'b1) stall_n++;
            else begin
                done = 1'b1;
                break;
            end
        end
        if (!done) begin
            n_checks++;
            $display("FAIL stall_bound: stall never released, got %0d cycles, expected < 40", stall_n);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic bubble();
        ex_sig = '0;
        ex_alu = '0;
        ex_src2 = '0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({dmem_req, dmem_wr, dmem_addr, dmem_wdata} !== 34'd0)
            $display("FAIL reset_req: got req=%b wr=%b addr=%h wdata=%h, expected all 0", dmem_req, dmem_wr, dmem_addr, dmem_wdata);
        else n_pass++;
        n_checks++;
        if (MEM_rdata !== 16'h0 || mem_err !== 1'b0 || MEM_stall !== 1'b0)
            $display("FAIL reset_out: got rdata=%h err=%b stall=%b, expected 0 0 0", MEM_rdata, mem_err, MEM_stall);
        else n_pass++;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_rdata = '0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_load();
        int s, r;
        run_instr(1'b1, 1'b0, 16'h0040, 16'h0, 4'd0, 0, 16'h0, s, r);
        bubble();
        n_checks++;
        if (s != 2 || r != 1) $display("FAIL load_timing: got stall=%0d req=%0d, expected 2 1", s, r);
        else n_pass++;
        n_checks++;
        if (MEM_rdata !== 16'hBEEF) $display("FAIL load_hold: got %h, expected beef", MEM_rdata);
        else n_pass++;
    endtask

    task automatic test_store_fwd();
        int s, r;
        wb_rw = 1'b1; wb_rd = 4'd5; wb_data = 16'h2222;
        run_instr(1'b1, 1'b1, 16'h0080, 16'h1111, 4'd5, 1, 16'h2222, s, r);
        bubble();
        n_checks++;
        if (s != 3 || r != 2) $display("FAIL store_timing: got stall=%0d req=%0d, expected 3 2", s, r);
        else n_pass++;
        // Register 0 matches but is never a forwarding source.
        wb_rd = 4'd0;
        run_instr(1'b1, 1'b1, 16'h0082, 16'h1111, 4'd0, 0, 16'h1111, s, r);
        bubble();
        // The register ID does not match.
        wb_rd = 4'd6;
        run_instr(1'b1, 1'b1, 16'h0084, 16'h1111, 4'd5, 0, 16'h1111, s, r);
        bubble();
        // The register matches, but the WB instruction does not write.
        wb_rw = 1'b0; wb_rd = 4'd5;
        run_instr(1'b1, 1'b1, 16'h0086, 16'h3333, 4'd5, 0, 16'h3333, s, r);
        bubble();
        n_checks++;
        if (MEM_rdata !== 16'hBEEF) $display("FAIL store_rdata: got %h, expected beef", MEM_rdata);
        else n_pass++;
    endtask

    task automatic test_wait_states();
        int s, r;
        wb_rw = 1'b1; wb_rd = 4'd3; wb_data = 16'h7777;
        run_instr(1'b1, 1'b1, 16'h0100, 16'h4444, 4'd3, 4, 16'h7777, s, r);
        bubble();
        n_checks++;
        if (s != 6 || r != 5) $display("FAIL wait_timing: got stall=%0d req=%0d, expected 6 5", s, r);
        else n_pass++;
        wb_rw = 1'b0;
        n_checks++;
        if (req_q.size() != 0) $display("FAIL wait_single_req: got %0d pending, expected 0", req_q.size());
        else n_pass++;
    endtask

    task automatic test_non_mem();
        int s, r;
        run_instr(1'b0, 1'b1, 16'h0F00, 16'hDEAD, 4'd0, 0, 16'h0, s, r);
        bubble();
        n_checks++;
        if (s != 0 || r != 0 || MEM_rdata !== 16'hBEEF)
            $display("FAIL non_mem: got stall=%0d req=%0d rdata=%h, expected 0 0 beef", s, r, MEM_rdata);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int s1, r1, s2, r2;
        run_instr(1'b1, 1'b0, 16'h0010, 16'h0, 4'd0, 0, 16'h0, s1, r1);
        run_instr(1'b1, 1'b0, 16'h0012, 16'h0, 4'd0, 0, 16'h0, s2, r2);
        bubble();
        n_checks++;
        if (s1 != 2 || s2 != 2 || r1 != 1 || r2 != 1)
            $display("FAIL b2b_timing: got stall=%0d,%0d req=%0d,%0d, expected 2,2 1,1", s1, s2, r1, r2);
        else n_pass++;
        n_checks++;
        if (MEM_rdata !== (16'h0012 ^ 16'hA5A5)) $display("FAIL b2b_rdata: got %h, expected %h", MEM_rdata, 16'h0012 ^ 16'hA5A5);
        else n_pass++;
    endtask

    task automatic test_timeout();
        int s, r;
        run_instr(1'b1, 1'b0, 16'h0200, 16'h0, 4'd0, 1000, 16'h0, s, r);
        bubble();
        n_checks++;
        if (s != TO + 1 || r != TO) $display("FAIL timeout_timing: got stall=%0d req=%0d, expected %0d %0d", s, r, TO + 1, TO);
        else n_pass++;
        repeat (3) begin @(posedge clk); #1; end
        @(negedge clk);
        n_checks++;
        if (mem_err !== 1'b1 || MEM_rdata !== 16'h0 || dmem_req !== 1'b0 || MEM_stall !== 1'b0)
            $display("FAIL timeout_state: got err=%b rdata=%h req=%b stall=%b, expected 1 0000 0 0", mem_err, MEM_rdata, dmem_req, MEM_stall);
        else n_pass++;
        @(posedge clk);
        #1;
        run_instr(1'b1, 1'b0, 16'h0040, 16'h0, 4'd0, 0, 16'h0, s, r);
        bubble();
        n_checks++;
        if (s != 2 || mem_err !== 1'b1) $display("FAIL timeout_recover: got stall=%0d err=%b, expected 2 1", s, mem_err);
        else n_pass++;
    endtask

    task automatic test_reset_mid_busy();
        rsp_en = 1'b0;
        manual_ready = 1'b0;
        manual_rdata = 16'h5A5A;
        ex_alu = 16'h0300;
        ex_sig = {16'h0, 1'b1, 1'b0};
        req_q.push_back('{1'b0, 16'h0300, 16'h0});
        repeat (3) @(negedge clk);
        n_checks++;
        if (dmem_req !== 1'b1 || MEM_stall !== 1'b1) $display("FAIL rst_busy_pre: got req=%b stall=%b, expected 1 1", dmem_req, MEM_stall);
        else n_pass++;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        ex_sig = '0;
        ex_alu = '0;
        manual_ready = 1'b1;
        exp_rdata = '0;
        @(negedge clk);
        n_checks++;
        if ({dmem_req, dmem_wr, dmem_addr, dmem_wdata} !== 34'd0 || MEM_rdata !== 16'h0 || mem_err !== 1'b0)
            $display("FAIL rst_busy_clear: got req=%b wr=%b addr=%h wdata=%h rdata=%h err=%b, expected all 0",
                     dmem_req, dmem_wr, dmem_addr, dmem_wdata, MEM_rdata, mem_err);
        else n_pass++;
        @(posedge clk);
        #1;
        manual_ready = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (dmem_req !== 1'b0 || MEM_stall !== 1'b0 || MEM_rdata !== 16'h0)
            $display("FAIL rst_busy_late_ready: got req=%b stall=%b rdata=%h, expected 0 0 0000", dmem_req, MEM_stall, MEM_rdata);
        else n_pass++;
        rsp_en = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (req_q.size() != 0 || rd_q.size() != 0)
            $display("FAIL scoreboard_drain: got %0d req %0d rdata pending, expected 0 0", req_q.size(), rd_q.size());
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_load();
        test_store_fwd();
        test_wait_states();
        test_non_mem();
        test_back_to_back();
        test_timeout();
        test_reset_mid_busy();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
